// File: rtl/lfsr_checker.sv
// Self-synchronising checker for a parallel LFSR pattern stream: locks after a run
// of predicted words, then free-runs its own LFSR copy and counts words and mismatches.
module lfsr_checker #(
    parameter int unsigned      WIDTH    = 4,
    parameter logic [WIDTH-1:0] TAPS     = 4'b1001,
    parameter int unsigned      LOCK_CNT = 4,
    parameter int unsigned      LOSS_CNT = 3
) (
    input  logic             Clk,
    input  logic             Set,
    input  logic             Valid,
    input  logic [WIDTH-1:0] Data,
    output logic             Locked,
    output logic             Err,
    output logic [15:0]      Err_cnt,
    output logic [15:0]      Word_cnt
);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_TGT = 4'(LOSS_CNT);

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        return {^(s & TAPS), s[WIDTH-1:1]};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             have_prev_q, have_prev_d;
    logic [3:0]       run_q, run_d;
    logic [3:0]       miss_q, miss_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             err_q, err_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic [15:0]      word_cnt_q, word_cnt_d;

    logic             match;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        have_prev_d = have_prev_q;
        run_d       = run_q;
        miss_d      = miss_q;
        exp_d       = exp_q;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;
        word_cnt_d  = word_cnt_q;
        match       = have_prev_q && (Data != '0) && (Data == lfsr_next(last_q));

        if (Valid) begin
            unique case (state_q)
                SEARCH: begin
                    last_d      = Data;
                    have_prev_d = 1'b1;
                    if (match) begin
                        run_d = run_q + 4'd1;
                        if (run_q + 4'd1 == LOCK_TGT) begin
                            state_d = LOCKED;
                            exp_d   = lfsr_next(Data);
                            miss_d  = '0;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                LOCKED: begin
                    // The flywheel never reseeds from received data, so one bad word costs one error.
                    exp_d      = lfsr_next(exp_q);
                    word_cnt_d = (word_cnt_q == '1) ? word_cnt_q : word_cnt_q + 16'd1;
                    if (Data == exp_q) begin
                        miss_d = '0;
                    end else begin
                        err_d     = 1'b1;
                        err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 16'd1;
                        miss_d    = miss_q + 4'd1;
                        if (miss_q + 4'd1 == LOSS_TGT) begin
                            state_d     = SEARCH;
                            run_d       = '0;
                            last_d      = Data;
                            have_prev_d = 1'b1;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Set) begin
            state_q     <= SEARCH;
            last_q      <= '0;
            have_prev_q <= 1'b0;
            run_q       <= '0;
            miss_q      <= '0;
            exp_q       <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            have_prev_q <= have_prev_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            exp_q       <= exp_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign Locked   = (state_q == LOCKED);
    assign Err      = err_q;
    assign Err_cnt  = err_cnt_q;
    assign Word_cnt = word_cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench: two checkers (x^4+x^3+1 and x^4+x+1) share one input stream and
// are compared each cycle against a behavioural model of the locking rules.
module tb_lfsr_checker;

    localparam int LOCK = 4;
    localparam int LOSS = 3;

    logic        Clk = 1'b0;
    logic        Set = 1'b0;
    logic        Valid = 1'b0;
    logic [3:0]  Data = '0;
    logic        a_locked, a_err, b_locked, b_err;
    logic [15:0] a_ec, a_wc, b_ec, b_wc;

    always #5 Clk = ~Clk;

    lfsr_checker #(.WIDTH(4), .TAPS(4'b1001), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS)) dut_a (
        .Clk(Clk), .Set(Set), .Valid(Valid), .Data(Data),
        .Locked(a_locked), .Err(a_err), .Err_cnt(a_ec), .Word_cnt(a_wc)
    );

    lfsr_checker #(.WIDTH(4), .TAPS(4'b0011), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS)) dut_b (
        .Clk(Clk), .Set(Set), .Valid(Valid), .Data(Data),
        .Locked(b_locked), .Err(b_err), .Err_cnt(b_ec), .Word_cnt(b_wc)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Next LFSR word by counting tapped ones: new MSB is their parity.
    function automatic int nxt(input int s, input int taps);
        int p = 0;
        for (int b = 0; b < 4; b++) if (((s & taps) >> b) & 1) p++;
        return (s >> 1) | ((p % 2) << 3);
    endfunction

    int m_taps [2] = '{9, 3};
    int m_last [2], m_have [2], m_run [2], m_miss [2], m_exp [2];
    int m_lock [2], m_err [2], m_ec [2], m_wc [2];

    typedef struct {
        int inst;
        int locked;
        int err;
        int ec;
        int wc;
    } exp_t;
    exp_t sb[$];

    task automatic model_step(input int i, input bit s, input bit v, input int d);
        if (s) begin
            m_last[i] = 0; m_have[i] = 0; m_run[i] = 0; m_miss[i] = 0; m_exp[i] = 0;
            m_lock[i] = 0; m_err[i] = 0; m_ec[i] = 0; m_wc[i] = 0;
        end else if (!v) begin
            m_err[i] = 0;
        end else if (!m_lock[i]) begin
            m_err[i] = 0;
            if (m_have[i] != 0 && d != 0 && d == nxt(m_last[i], m_taps[i])) begin
                m_run[i]++;
                if (m_run[i] == LOCK) begin
                    m_lock[i] = 1;
                    m_exp[i]  = nxt(d, m_taps[i]);
                    m_miss[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
            m_last[i] = d;
            m_have[i] = 1;
        end else begin
            if (m_wc[i] < 65535) m_wc[i]++;
            if (d == m_exp[i]) begin
                m_miss[i] = 0;
                m_err[i]  = 0;
            end else begin
                m_err[i] = 1;
                if (m_ec[i] < 65535) m_ec[i]++;
                m_miss[i]++;
                if (m_miss[i] == LOSS) begin
                    m_lock[i] = 0;
                    m_run[i]  = 0;
                    m_last[i] = d;
                    m_have[i] = 1;
                end
            end
            m_exp[i] = nxt(m_exp[i], m_taps[i]);
        end
    endtask

    task automatic drive(input bit s, input bit v, input int d);
        exp_t e;
        @(negedge Clk);
        Set   = s;
        Valid = v;
        Data  = 4'(d);
        model_step(0, s, v, d);
        model_step(1, s, v, d);
        @(posedge Clk);
        for (int i = 0; i < 2; i++) begin
            e.inst = i; e.locked = m_lock[i]; e.err = m_err[i]; e.ec = m_ec[i]; e.wc = m_wc[i];
            sb.push_back(e);
        end
    endtask

    always @(negedge Clk) begin
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.inst == 0) begin
                check("a_locked", int'(a_locked), e.locked);
                check("a_err", int'(a_err), e.err);
                check("a_err_cnt", int'(a_ec), e.ec);
                check("a_word_cnt", int'(a_wc), e.wc);
            end else begin
                check("b_locked", int'(b_locked), e.locked);
                check("b_err", int'(b_err), e.err);
                check("b_err_cnt", int'(b_ec), e.ec);
                check("b_word_cnt", int'(b_wc), e.wc);
            end
        end
    end

    int cur;

    task automatic good_word(input int taps);
        drive(1'b0, 1'b1, cur);
        cur = nxt(cur, taps);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1);
    end

    initial begin
        // Reset state.
        drive(1'b1, 1'b0, 0);
        drive(1'b1, 1'b1, 15);
        #2;
        check("reset_locked", int'(a_locked), 0);
        check("reset_err_cnt", int'(a_ec), 0);
        check("reset_word_cnt", int'(a_wc), 0);

        // Clean x^4+x^3+1 stream from 1111: lock after the 5th word.
        cur = 15;
        for (int k = 0; k < 305; k++) begin
            good_word(9);
            if (k == 3) begin #2; check("not_locked_after_4", int'(a_locked), 0); end
            if (k == 4) begin #2; check("locked_after_5", int'(a_locked), 1); end
        end
        #2;
        check("word_cnt_300", int'(a_wc), 300);
        check("clean_err_cnt", int'(a_ec), 0);

        // Single corrupted word: expected 0101 replaced by 0100.
        while (cur != 5) good_word(9);
        drive(1'b0, 1'b1, 4);
        cur = nxt(cur, 9);
        #2;
        check("single_err_pulse", int'(a_err), 1);
        good_word(9);
        #2;
        check("single_err_cleared", int'(a_err), 0);
        for (int k = 0; k < 20; k++) good_word(9);
        #2;
        check("single_err_cnt", int'(a_ec), 1);
        check("single_still_locked", int'(a_locked), 1);

        // Three consecutive wrong words drop lock.
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, cur ^ $urandom_range(1, 15));
            cur = nxt(cur, 9);
            #2;
            check("burst_err_pulse", int'(a_err), 1);
        end
        check("burst_unlocked", int'(a_locked), 0);
        check("burst_err_cnt", int'(a_ec), 4);
        for (int k = 0; k < 5; k++) good_word(9);
        #2;
        check("relocked", int'(a_locked), 1);
        check("relock_err_cnt_held", int'(a_ec), 4);

        // Stuck-at-0 then a foreign-polynomial stream never locks the 1001 checker.
        drive(1'b1, 1'b0, 0);
        for (int k = 0; k < 50; k++) drive(1'b0, 1'b1, 0);
        cur = $urandom_range(1, 15);
        for (int k = 0; k < 40; k++) begin
            good_word(3);
            #2;
            check("foreign_never_locks", int'(a_locked), 0);
        end
        check("foreign_err_cnt", int'(a_ec), 0);

        // x^4+x+1 stream with Valid gaps of 1..3 cycles.
        drive(1'b1, 1'b0, 0);
        cur = $urandom_range(1, 15);
        for (int k = 0; k < 200; k++) begin
            good_word(3);
            if ($urandom_range(0, 2) == 0) begin
                int g = $urandom_range(1, 3);
                for (int j = 0; j < g; j++) drive(1'b0, 1'b0, $urandom_range(0, 15));
            end
        end
        #2;
        check("gap_locked", int'(b_locked), 1);
        check("gap_err_cnt", int'(b_ec), 0);

        // Build Err_cnt=5 while locked, then a one-cycle Set.
        drive(1'b1, 1'b0, 0);
        cur = 15;
        for (int k = 0; k < 10; k++) good_word(9);
        for (int n = 0; n < 5; n++) begin
            drive(1'b0, 1'b1, cur ^ 8);
            cur = nxt(cur, 9);
            for (int k = 0; k < 3; k++) good_word(9);
        end
        #2;
        check("five_err_cnt", int'(a_ec), 5);
        check("five_locked", int'(a_locked), 1);
        drive(1'b1, 1'b1, cur);
        #2;
        check("set_locked", int'(a_locked), 0);
        check("set_err", int'(a_err), 0);
        check("set_err_cnt", int'(a_ec), 0);
        check("set_word_cnt", int'(a_wc), 0);
        for (int k = 0; k < 5; k++) good_word(9);
        #2;
        check("set_relock", int'(a_locked), 1);

        // Randomised mix: stream switching, corruption, gaps and occasional Set.
        for (int seg = 0; seg < 8; seg++) begin
            int taps = (seg % 2 == 0) ? 9 : 3;
            cur = $urandom_range(1, 15);
            for (int k = 0; k < 200; k++) begin
                int r = $urandom_range(0, 99);
                if (r < 1)       drive(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 15));
                else if (r < 15) drive(1'b0, 1'b0, $urandom_range(0, 15));
                else if (r < 20) begin
                    drive(1'b0, 1'b1, $urandom_range(0, 15));
                    cur = nxt(cur, taps);
                end else good_word(taps);
            end
        end

        @(negedge Clk);
        @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Response-side checker for the 4-bit LFSR test pattern generators: it consumes the parallel pattern word stream and self-synchronises to it. After lock it free-runs its own copy of the LFSR (flywheel) and compares each incoming word against it, flagging and counting mismatches. It sits at the far end of a pattern path, for example after a link or a DUT pass-through, alongside the MISR response analyzer. It gives a per-word error indication where the MISR gives only a final signature.

## Interface
- WIDTH, 4: LFSR/data width in bits.
- TAPS, 4'b1001: feedback tap mask. Feedback = XOR of Q[i] for every i with TAPS[i]=1. 4'b1001 matches x^4+x^3+1 (Q0^Q3); 4'b0011 matches x^4+x+1 (Q0^Q1).
- LOCK_CNT, 4: consecutive predicted matches required to lock (legal range 1..15).
- LOSS_CNT, 3: consecutive mismatches while locked that drop lock (legal range 1..15).

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Set  in  1  synchronous, active-high reset.
- Valid  in  1  Data is a pattern word this cycle.
- Data  in  WIDTH  received pattern word (standard form LFSR state Q[WIDTH-1:0]).
- Locked  out  1  checker is in LOCKED state.
- Err  out  1  one-cycle pulse: the previous sampled word mismatched while locked.
- Err_cnt  out  16  mismatches while locked; saturates at 16'hFFFF.
- Word_cnt  out  16  words checked while locked; saturates at 16'hFFFF.

## Operation
- Next-state function: f(S) = {^(S & TAPS), S[WIDTH-1:1]}. New bit enters the MSB; the shift goes MSB toward LSB.
- Internal registers:
  - last: previous word.
  - have_prev: a previous word is held.
  - run: match run counter.
  - miss: miss run counter.
  - exp: expected word.
  - state: SEARCH or LOCKED.
- Set=1 clears all registers and outputs to 0, including Locked, Err and both counters. State becomes SEARCH. Set overrides Valid.
- Valid=0: nothing changes except Err, which goes to 0.
- SEARCH, Valid=1:
  - A word is a match when have_prev=1, Data≠0, and Data==f(last). On a match, run<=run+1; otherwise run<=0.
  - last<=Data; have_prev<=1.
  - When a match makes run+1==LOCK_CNT: state<=LOCKED, exp<=f(Data), miss<=0.
  - Err stays 0; counters do not change.
- LOCKED, Valid=1:
  - Word_cnt increments (saturating).
  - If Data==exp: miss<=0.
  - Otherwise: Err<=1, Err_cnt increments (saturating), miss<=miss+1.
  - exp<=f(exp) always. The received data never reseeds exp, so a single corrupted word produces exactly one error.
  - When a mismatch makes miss+1==LOSS_CNT: state<=SEARCH, run<=0, last<=Data, have_prev<=1. Err still pulses for this word.
  - Err_cnt and Word_cnt keep their values across loss of lock; only Set clears them.
- The all-zero word never counts as a match in SEARCH, so the checker cannot lock onto a stuck-at-0 stream. In LOCKED, an all-zero word is an ordinary mismatch.

## Timing
- All outputs are registered. Response latency is 1 cycle: the Err, Locked and counter values reflecting the word sampled at edge k are visible after edge k.
- Minimum time to lock is LOCK_CNT+1 Valid words: one word seeds last, then LOCK_CNT matches follow.
- Gaps in Valid are transparent: the LFSR advances per Valid word, not per clock.
- Set arriving mid-run, in any state, returns to the reset state at that edge. The word presented with Set is discarded.

## Test plan
- TAPS=1001: after Set, stream 1111, 0111, 1011, 0101, 1010, then continue the sequence 1101, 0110, 0011, 1001, 0100, 0010, 0001, 1000, 1100, 1110 and wrap.
  - Required: Locked=1 after the 5th word (1010).
  - Required: Err stays 0 for 300 words.
  - Required: Word_cnt equals the number of words after lock.
- While locked, replace a single expected 0101 with 0100.
  - Required: exactly one Err pulse, 1 cycle after that word.
  - Required: Err_cnt=1 and Locked stays 1.
  - Required: following words check clean.
- While locked, send 3 consecutive wrong words.
  - Required: 3 Err pulses, Err_cnt+=3.
  - Required: Locked=0 after the 3rd; Err_cnt is held.
  - Required: re-lock after 4 further good matches.
- Feed constant 0000 for 50 words, then an x^4+x+1 stream into a TAPS=1001 checker.
  - Required: Locked never asserts; Err and Err_cnt stay 0.
- Interleave Valid=0 gaps of 1–3 cycles into a clean TAPS=0011 stream.
  - Required: lock is achieved and held, with Err=0 throughout.
- Assert Set for 1 cycle while locked with Err_cnt=5.
  - Required: all outputs are 0 next cycle, and the normal lock sequence works again.
